// File: rtl/exu_wbu.sv
// exu_wbu: writeback unit behind the ALU.
// The ALU result, an LSU load result and an MDU result share the single
// register-file write port, which is driven through one output register.
// The ALU cannot be back-pressured, so it always owns the port when it writes
// a non-zero register. LSU and MDU results wait in 1-entry holding buffers.
// When both buffers contend, a round-robin pointer picks the winner.
// Optional feature macro: EXU_WBU_STARVE_GUARD_EN
//   defined   : per-buffer age counters raise stall_o after STARVE_LIMIT
//               denied cycles
//   undefined : no age counters; stall_o is constant 0

module exu_wbu #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_we_i,
    input  logic [ADDR_W-1:0] alu_waddr_i,
    input  logic [DATA_W-1:0] alu_wdata_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [ADDR_W-1:0] lsu_waddr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic              mdu_valid_i,
    output logic              mdu_ready_o,
    input  logic [ADDR_W-1:0] mdu_waddr_i,
    input  logic [DATA_W-1:0] mdu_wdata_i,
    output logic              stall_o,
    output logic              reg_we_o,
    output logic [ADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0] reg_wdata_o
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

    // holding buffers
    logic              r_lsu_full;
    logic [ADDR_W-1:0] r_lsu_addr;
    logic [DATA_W-1:0] r_lsu_data;
    logic              r_mdu_full;
    logic [ADDR_W-1:0] r_mdu_addr;
    logic [DATA_W-1:0] r_mdu_data;

    // round-robin pointer: 0 prefers LSU, 1 prefers MDU
    logic              r_rr_mdu;

    // write-port output register
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    // decode and arbitration
    logic              w_alu_win;
    logic              w_lsu_elig;
    logic              w_mdu_elig;
    logic              w_lsu_zero;
    logic              w_mdu_zero;
    logic              w_lsu_cap;
    logic              w_mdu_cap;
    logic              w_gnt_lsu;
    logic              w_gnt_mdu;
    logic              w_rr_step;

    // age terms; constant zero when the starvation guard is compiled out
    logic [AGE_W-1:0]  w_age_lsu;
    logic [AGE_W-1:0]  w_age_mdu;

    // An ALU write to x0 is dropped and leaves the port free for a buffer.
    assign w_alu_win  = alu_we_i & (alu_waddr_i != '0);

    // A buffer holding an x0 result never competes for the port; it is
    // simply emptied on the next edge.
    assign w_lsu_elig = r_lsu_full & (r_lsu_addr != '0);
    assign w_mdu_elig = r_mdu_full & (r_mdu_addr != '0);
    assign w_lsu_zero = r_lsu_full & (r_lsu_addr == '0);
    assign w_mdu_zero = r_mdu_full & (r_mdu_addr == '0);

    // Ready depends only on buffer state, so there is no path from valid to
    // ready. A buffer drained this cycle shows ready only from the next cycle.
    assign lsu_ready_o = ~r_lsu_full;
    assign mdu_ready_o = ~r_mdu_full;
    assign w_lsu_cap   = lsu_valid_i & ~r_lsu_full;
    assign w_mdu_cap   = mdu_valid_i & ~r_mdu_full;

    // Port grant: ALU first, then a single eligible buffer, then round-robin.
    // The pointer only advances when it actually decided a contest, so a
    // buffer that wins uncontested does not cost it its next turn.
    always_comb begin
        w_gnt_lsu = 1'b0;
        w_gnt_mdu = 1'b0;
        w_rr_step = 1'b0;
        if (!w_alu_win) begin
            if (w_lsu_elig && w_mdu_elig) begin
                w_rr_step = 1'b1;
                if (r_rr_mdu) begin
                    w_gnt_mdu = 1'b1;
                end else begin
                    w_gnt_lsu = 1'b1;
                end
            end else begin
                w_gnt_lsu = w_lsu_elig;
                w_gnt_mdu = w_mdu_elig;
            end
        end
    end

    // LSU holding buffer: capture when empty, empty on grant or x0 target.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lsu_full <= 1'b0;
            r_lsu_addr <= '0;
            r_lsu_data <= '0;
        end else if (w_lsu_cap) begin
            r_lsu_full <= 1'b1;
            r_lsu_addr <= lsu_waddr_i;
            r_lsu_data <= lsu_wdata_i;
        end else if (w_gnt_lsu || w_lsu_zero) begin
            r_lsu_full <= 1'b0;
        end
    end

    // MDU holding buffer: same policy as the LSU buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mdu_full <= 1'b0;
            r_mdu_addr <= '0;
            r_mdu_data <= '0;
        end else if (w_mdu_cap) begin
            r_mdu_full <= 1'b1;
            r_mdu_addr <= mdu_waddr_i;
            r_mdu_data <= mdu_wdata_i;
        end else if (w_gnt_mdu || w_mdu_zero) begin
            r_mdu_full <= 1'b0;
        end
    end

    // Round-robin pointer toggles after each contested buffer grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_mdu <= 1'b0;
        end else if (w_rr_step) begin
            r_rr_mdu <= ~r_rr_mdu;
        end
    end

    // Output stage: register the granted entry; hold addr/data when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_alu_win) begin
            r_we    <= 1'b1;
            r_waddr <= alu_waddr_i;
            r_wdata <= alu_wdata_i;
        end else if (w_gnt_lsu) begin
            r_we    <= 1'b1;
            r_waddr <= r_lsu_addr;
            r_wdata <= r_lsu_data;
        end else if (w_gnt_mdu) begin
            r_we    <= 1'b1;
            r_waddr <= r_mdu_addr;
            r_wdata <= r_mdu_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign reg_we_o    = r_we;
    assign reg_waddr_o = r_waddr;
    assign reg_wdata_o = r_wdata;

`ifdef EXU_WBU_STARVE_GUARD_EN
    logic [AGE_W-1:0] r_age_lsu;
    logic [AGE_W-1:0] r_age_mdu;

    // Age counters: count denied cycles of a held result, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_age_lsu <= '0;
            r_age_mdu <= '0;
        end else begin
            if (!r_lsu_full || w_gnt_lsu) begin
                r_age_lsu <= '0;
            end else if (r_age_lsu != AGE_W'(STARVE_LIMIT)) begin
                r_age_lsu <= r_age_lsu + AGE_W'(1);
            end
            if (!r_mdu_full || w_gnt_mdu) begin
                r_age_mdu <= '0;
            end else if (r_age_mdu != AGE_W'(STARVE_LIMIT)) begin
                r_age_mdu <= r_age_mdu + AGE_W'(1);
            end
        end
    end

    assign w_age_lsu = r_age_lsu;
    assign w_age_mdu = r_age_mdu;
`else
    // Without the guard a held result may wait indefinitely behind the ALU.
    assign w_age_lsu = '0;
    assign w_age_mdu = '0;
`endif

    // Stall is decoded purely from the age registers.
    assign stall_o = (w_age_lsu == AGE_W'(STARVE_LIMIT)) |
                     (w_age_mdu == AGE_W'(STARVE_LIMIT));

    // The issue stage should hold ALU ops while stalled; the ALU still wins
    // if it does not, but flag it in simulation.
    a_alu_during_stall: assert property (
        @(posedge clk) disable iff (rst) !(alu_we_i && stall_o)
    );

endmodule

// File: tb/tb_exu_wbu.sv
// tb_exu_wbu: table vectors, directed multi-cycle sequences and a randomized
// run against a behavioural model of the writeback unit.
// Honours EXU_WBU_STARVE_GUARD_EN the same way the design does.

module tb_exu_wbu;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int LIMIT = 4;
`ifdef EXU_WBU_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_we_i;
    logic [AW-1:0] alu_waddr_i;
    logic [DW-1:0] alu_wdata_i;
    logic          lsu_valid_i;
    logic          lsu_ready_o;
    logic [AW-1:0] lsu_waddr_i;
    logic [DW-1:0] lsu_wdata_i;
    logic          mdu_valid_i;
    logic          mdu_ready_o;
    logic [AW-1:0] mdu_waddr_i;
    logic [DW-1:0] mdu_wdata_i;
    logic          stall_o;
    logic          reg_we_o;
    logic [AW-1:0] reg_waddr_o;
    logic [DW-1:0] reg_wdata_o;

    int n_vec = 0;
    int n_err = 0;

    exu_wbu #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_we_i    (alu_we_i),
        .alu_waddr_i (alu_waddr_i),
        .alu_wdata_i (alu_wdata_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_ready_o (lsu_ready_o),
        .lsu_waddr_i (lsu_waddr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .mdu_valid_i (mdu_valid_i),
        .mdu_ready_o (mdu_ready_o),
        .mdu_waddr_i (mdu_waddr_i),
        .mdu_wdata_i (mdu_wdata_i),
        .stall_o     (stall_o),
        .reg_we_o    (reg_we_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_wdata_o (reg_wdata_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " we"},    DW'(reg_we_o),    0);
        chk({tag, " waddr"}, DW'(reg_waddr_o), 0);
        chk({tag, " wdata"}, reg_wdata_o,      0);
        chk({tag, " lrdy"},  DW'(lsu_ready_o), 1);
        chk({tag, " mrdy"},  DW'(mdu_ready_o), 1);
        chk({tag, " stall"}, DW'(stall_o),     0);
    endtask

    task automatic idle_inputs();
        alu_we_i    = 1'b0;
        lsu_valid_i = 1'b0;
        mdu_valid_i = 1'b0;
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 = LSU, 1 = MDU, 2 = ALU as the port owner.
    bit          m_full[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_data[2];
    int          m_age[2];
    int          m_pref;
    bit          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit          m_stall;

    task automatic model_step();
        bit            vin[2];
        logic [AW-1:0] ain[2];
        logic [DW-1:0] din[2];
        bit            elig[2];
        int            owner;
        vin[0] = lsu_valid_i; ain[0] = lsu_waddr_i; din[0] = lsu_wdata_i;
        vin[1] = mdu_valid_i; ain[1] = mdu_waddr_i; din[1] = mdu_wdata_i;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_full[k] = 0; m_addr[k] = '0; m_data[k] = '0; m_age[k] = 0;
            end
            m_pref = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_stall = 0;
            return;
        end
        for (int k = 0; k < 2; k++) elig[k] = m_full[k] && (m_addr[k] != 0);
        owner = -1;
        if (alu_we_i && alu_waddr_i != 0) owner = 2;
        else if (elig[0] && elig[1]) begin
            owner  = m_pref;
            m_pref = 1 - m_pref;
        end else if (elig[0]) owner = 0;
        else if (elig[1]) owner = 1;

        m_we = (owner >= 0);
        if (owner == 2) begin
            m_waddr = alu_waddr_i; m_wdata = alu_wdata_i;
        end else if (owner >= 0) begin
            m_waddr = m_addr[owner]; m_wdata = m_data[owner];
        end

        for (int k = 0; k < 2; k++) begin
            if (!m_full[k] || owner == k) m_age[k] = 0;
            else if (m_age[k] < LIMIT) m_age[k] = m_age[k] + 1;
            if (m_full[k]) begin
                if (owner == k || m_addr[k] == 0) m_full[k] = 0;
            end else if (vin[k]) begin
                m_full[k] = 1; m_addr[k] = ain[k]; m_data[k] = din[k];
            end
        end
        m_stall = GUARD && (m_age[0] == LIMIT || m_age[1] == LIMIT);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          exp_we;
        logic [AW-1:0] exp_waddr;
        logic [DW-1:0] exp_wdata;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b1, 5'd5,  32'h0000_1234};
        tbl[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
        tbl[2] = '{1'b0, 5'd3,  32'h0000_AAAA, 1'b0, 5'd31, 32'hFFFF_FFFF};
        tbl[3] = '{1'b1, 5'd0,  32'h0000_5555, 1'b0, 5'd31, 32'hFFFF_FFFF};
        tbl[4] = '{1'b1, 5'd1,  32'h0000_0001, 1'b1, 5'd1,  32'h0000_0001};
        tbl[5] = '{1'b1, 5'd2,  32'h8000_0000, 1'b1, 5'd2,  32'h8000_0000};

        rst = 1'b1;
        idle_inputs();
        alu_waddr_i = '0; alu_wdata_i = '0;
        lsu_waddr_i = '0; lsu_wdata_i = '0;
        mdu_waddr_i = '0; mdu_wdata_i = '0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // ALU-only vectors, one cycle latency, x0 dropped, hold when idle
        for (int i = 0; i < 6; i++) begin
            alu_we_i = tbl[i].we; alu_waddr_i = tbl[i].waddr; alu_wdata_i = tbl[i].wdata;
            tick();
            chk($sformatf("tbl%0d we", i),    DW'(reg_we_o),    DW'(tbl[i].exp_we));
            chk($sformatf("tbl%0d waddr", i), DW'(reg_waddr_o), DW'(tbl[i].exp_waddr));
            chk($sformatf("tbl%0d wdata", i), reg_wdata_o,      tbl[i].exp_wdata);
        end
        idle_inputs();
        tick();

        // LSU single result, ALU idle
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'hA5A5;
        tick();
        lsu_valid_i = 1'b0;
        chk("lsu cap rdy", DW'(lsu_ready_o), 0);
        chk("lsu cap we",  DW'(reg_we_o),    0);
        tick();
        chk("lsu wr we",    DW'(reg_we_o),    1);
        chk("lsu wr waddr", DW'(reg_waddr_o), 7);
        chk("lsu wr wdata", reg_wdata_o,      32'hA5A5);
        chk("lsu wr rdy",   DW'(lsu_ready_o), 1);
        tick();
        chk("lsu after we", DW'(reg_we_o), 0);

        // Both buffers at once: LSU first, then MDU; next contest goes to MDU
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd3; lsu_wdata_i = 32'h3333;
        mdu_valid_i = 1'b1; mdu_waddr_i = 5'd4; mdu_wdata_i = 32'h4444;
        tick();
        idle_inputs();
        chk("both cap lrdy", DW'(lsu_ready_o), 0);
        chk("both cap mrdy", DW'(mdu_ready_o), 0);
        tick();
        chk("both 1st waddr", DW'(reg_waddr_o), 3);
        chk("both 1st wdata", reg_wdata_o,      32'h3333);
        tick();
        chk("both 2nd we",    DW'(reg_we_o),    1);
        chk("both 2nd waddr", DW'(reg_waddr_o), 4);
        chk("both 2nd mrdy",  DW'(mdu_ready_o), 1);
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd10; lsu_wdata_i = 32'hAAAA_0010;
        mdu_valid_i = 1'b1; mdu_waddr_i = 5'd11; mdu_wdata_i = 32'hBBBB_0011;
        tick();
        idle_inputs();
        tick();
        chk("rr 1st waddr", DW'(reg_waddr_o), 11);
        chk("rr 1st wdata", reg_wdata_o,      32'hBBBB_0011);
        tick();
        chk("rr 2nd waddr", DW'(reg_waddr_o), 10);
        tick();

        // MDU held behind continuous ALU traffic
        alu_we_i = 1'b1; alu_waddr_i = 5'd1; alu_wdata_i = 32'h1;
        mdu_valid_i = 1'b1; mdu_waddr_i = 5'd9; mdu_wdata_i = 32'h9999;
        tick();
        mdu_valid_i = 1'b0;
`ifdef EXU_WBU_STARVE_GUARD_EN
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("starve d%0d stall", i), DW'(stall_o), (i == 4) ? 1 : 0);
        end
`else
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("noguard d%0d stall", i), DW'(stall_o), 0);
        end
        chk("noguard held mrdy", DW'(mdu_ready_o), 0);
`endif
        alu_we_i = 1'b0;
        tick();
        chk("starve wr we",    DW'(reg_we_o),    1);
        chk("starve wr waddr", DW'(reg_waddr_o), 9);
        chk("starve wr wdata", reg_wdata_o,      32'h9999);
        chk("starve clr",      DW'(stall_o),     0);
        tick();

        // MDU result to x0 is dropped
        mdu_valid_i = 1'b1; mdu_waddr_i = 5'd0; mdu_wdata_i = 32'hFFFF;
        tick();
        mdu_valid_i = 1'b0;
        chk("x0 cap mrdy", DW'(mdu_ready_o), 0);
        chk("x0 cap we",   DW'(reg_we_o),    0);
        tick();
        chk("x0 clr mrdy", DW'(mdu_ready_o), 1);
        chk("x0 clr we",   DW'(reg_we_o),    0);
        tick();
        chk("x0 after we", DW'(reg_we_o), 0);

        // Reset while both buffers hold results
        alu_we_i = 1'b1; alu_waddr_i = 5'd1; alu_wdata_i = 32'h77;
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd12; lsu_wdata_i = 32'hC12;
        mdu_valid_i = 1'b1; mdu_waddr_i = 5'd13; mdu_wdata_i = 32'hD13;
        tick();
        idle_inputs();
        chk("rstmid held", DW'({lsu_ready_o, mdu_ready_o}), 0);
        rst = 1'b1;
        tick();
        chk_reset_vals("rstmid");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rstmid drop%0d we", i), DW'(reg_we_o), 0);
        end

        // Randomized run against the model
        rst = 1'b1;
        model_step();
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst         = ($urandom_range(0, 199) == 0);
            alu_we_i    = !m_stall && ($urandom_range(0, 99) < 55);
            alu_waddr_i = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            alu_wdata_i = $urandom;
            lsu_valid_i = ($urandom_range(0, 99) < 40);
            lsu_waddr_i = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            lsu_wdata_i = $urandom;
            mdu_valid_i = ($urandom_range(0, 99) < 30);
            mdu_waddr_i = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            mdu_wdata_i = $urandom;
            model_step();
            tick();
            chk("rnd we",    DW'(reg_we_o),    DW'(m_we));
            chk("rnd waddr", DW'(reg_waddr_o), DW'(m_waddr));
            chk("rnd wdata", reg_wdata_o,      m_wdata);
            chk("rnd lrdy",  DW'(lsu_ready_o), DW'(!m_full[0]));
            chk("rnd mrdy",  DW'(mdu_ready_o), DW'(!m_full[1]));
            chk("rnd stall", DW'(stall_o),     DW'(m_stall));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
